// File: rtl/clock_set_ctrl_if.sv
// Signal bundle between the seconds stage, the buttons and the min/hr counters.
// master drives the carries and buttons; slave is the time-setting controller.
interface clock_set_ctrl_if;
    logic       sec_tick;
    logic       min_carry;
    logic       btn_mode;
    logic       btn_inc;
    logic       min_tick_o;
    logic       hr_tick_o;
    logic       sec_clr;
    logic [1:0] mode;
    logic       blink;

    modport master (
        output sec_tick, min_carry, btn_mode, btn_inc,
        input  min_tick_o, hr_tick_o, sec_clr, mode, blink
    );

    modport slave (
        input  sec_tick, min_carry, btn_mode, btn_inc,
        output min_tick_o, hr_tick_o, sec_clr, mode, blink
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-setting controller for the 24h clock: RUN pass-through, SET_HR/SET_MIN adjust.
// Optional feature macro: SET_AUTOREPEAT_EN (held btn_inc auto-repeats after REPEAT_DELAY).
module clock_set_ctrl #(
    parameter int TIMEOUT      = 10,
    parameter int REPEAT_DELAY = 2
) (
    input  logic             clk_1Hz,
    input  logic             rst,
    clock_set_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } state_t;

    state_t     r_state;
    logic       r_mode_q;
    logic       r_inc_q;
    logic       r_blink;
    logic       r_hr_pls;
    logic       r_min_pls;
    logic [5:0] r_tmo;

    logic w_mode_evt;
    logic w_inc_evt;
    logic w_set;
    logic w_rpt;
    logic w_fire;

    assign w_mode_evt = bus.btn_mode & ~r_mode_q;
    assign w_inc_evt  = bus.btn_inc & ~r_inc_q;
    assign w_set      = (r_state != RUN);

`ifdef SET_AUTOREPEAT_EN
    logic [3:0] r_hold;

    // r_hold counts held cycles since the press and saturates at REPEAT_DELAY
    assign w_rpt = w_set & bus.btn_inc & (r_hold >= 4'(REPEAT_DELAY));

    always_ff @(posedge clk_1Hz) begin
        if (rst)
            r_hold <= 4'd0;
        else if (w_mode_evt | ~bus.btn_inc | ~w_set)
            r_hold <= 4'd0;
        else if (w_inc_evt)
            r_hold <= 4'd1;
        else if ((r_hold != 4'd0) && (r_hold < 4'(REPEAT_DELAY)))
            r_hold <= r_hold + 4'd1;
    end
`else
    assign w_rpt = 1'b0;
`endif

    // a mode press in the same cycle swallows any adjustment
    assign w_fire = w_set & ~w_mode_evt & (w_inc_evt | w_rpt);

    always_ff @(posedge clk_1Hz) begin
        if (rst) begin
            r_state   <= RUN;
            r_mode_q  <= 1'b1;
            r_inc_q   <= 1'b1;
            r_tmo     <= 6'd0;
            r_blink   <= 1'b0;
            r_hr_pls  <= 1'b0;
            r_min_pls <= 1'b0;
        end else begin
            r_mode_q  <= bus.btn_mode;
            r_inc_q   <= bus.btn_inc;
            r_hr_pls  <= w_fire & (r_state == SET_HR);
            r_min_pls <= w_fire & (r_state == SET_MIN);
            r_blink   <= w_set ? ~r_blink : 1'b0;
            case (r_state)
                RUN: begin
                    r_tmo <= 6'd0;
                    if (w_mode_evt) r_state <= SET_HR;
                end
                SET_HR, SET_MIN: begin
                    if (w_mode_evt | w_inc_evt | bus.btn_inc) begin
                        r_tmo <= 6'd0;
                    end else if (r_tmo == 6'(TIMEOUT - 1)) begin
                        r_tmo   <= 6'd0;
                        r_state <= RUN;
                    end else begin
                        r_tmo <= r_tmo + 6'd1;
                    end
                    if (w_mode_evt) r_state <= (r_state == SET_HR) ? SET_MIN : RUN;
                end
                default: begin
                    r_tmo   <= 6'd0;
                    r_state <= RUN;
                end
            endcase
        end
    end

    // RUN forwards the carry chain with no added latency
    assign bus.min_tick_o = w_set ? r_min_pls : bus.sec_tick;
    assign bus.hr_tick_o  = w_set ? r_hr_pls  : bus.min_carry;
    assign bus.sec_clr    = w_set;
    assign bus.blink      = w_set & r_blink;
    assign bus.mode       = r_state;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed scenarios plus random buttons
// checked every cycle against a behavioural model of the setting rules.
module tb_clock_set_ctrl;
    localparam int TO = 10;
    localparam int RD = 2;

    logic clk_1Hz = 1'b0;
    logic rst     = 1'b1;
    always #5 clk_1Hz = ~clk_1Hz;

    clock_set_ctrl_if bus ();

    clock_set_ctrl #(.TIMEOUT(TO), .REPEAT_DELAY(RD)) u_dut (
        .clk_1Hz (clk_1Hz),
        .rst     (rst),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // model: current field, previous button samples, idle seconds, hold time, blink phase, pending pulses
    bit m_valid = 0;
    int m_st, m_mq, m_iq, m_idle, m_hold, m_bl, m_phr, m_pmin;

    int cnt_hr, cnt_min, obs_mode;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_upd(input int bm, input int bi, input int r);
        int me, ie, fire, nst;
        if (r != 0) begin
            m_st = 0; m_mq = 1; m_iq = 1; m_idle = 0; m_hold = 0;
            m_bl = 0; m_phr = 0; m_pmin = 0;
            m_valid = 1;
            return;
        end
        if (!m_valid) return;
        me   = (bm != 0 && m_mq == 0) ? 1 : 0;
        ie   = (bi != 0 && m_iq == 0) ? 1 : 0;
        nst  = m_st;
        fire = (m_st != 0 && me == 0 && ie != 0) ? 1 : 0;
`ifdef SET_AUTOREPEAT_EN
        if (m_st != 0 && me == 0 && bi != 0 && m_hold >= RD) fire = 1;
        if (me != 0 || bi == 0 || m_st == 0) m_hold = 0;
        else if (ie != 0) m_hold = 1;
        else if (m_hold > 0 && m_hold < RD) m_hold++;
`endif
        m_phr  = (fire != 0 && m_st == 1) ? 1 : 0;
        m_pmin = (fire != 0 && m_st == 2) ? 1 : 0;
        m_bl   = (m_st != 0) ? 1 - m_bl : 0;
        if (m_st == 0) m_idle = 0;
        else if (me != 0 || ie != 0 || bi != 0) m_idle = 0;
        else begin
            m_idle++;
            if (m_idle == TO) begin m_idle = 0; nst = 0; end
        end
        if (me != 0) nst = (m_st + 1) % 3;
        m_st = nst;
        m_mq = bm;
        m_iq = bi;
    endtask

    task automatic step(input int bm, input int bi, input int st, input int mc, input int r);
        @(negedge clk_1Hz);
        bus.btn_mode  = bm[0];
        bus.btn_inc   = bi[0];
        bus.sec_tick  = st[0];
        bus.min_carry = mc[0];
        rst           = r[0];
        #1;
        if (m_valid) begin
            chk("mode",    int'(bus.mode), m_st);
            chk("sec_clr", int'(bus.sec_clr), (m_st != 0) ? 1 : 0);
            chk("blink",   int'(bus.blink), (m_st != 0) ? m_bl : 0);
            chk("min_tick", int'(bus.min_tick_o), (m_st == 0) ? st : m_pmin);
            chk("hr_tick",  int'(bus.hr_tick_o),  (m_st == 0) ? mc : m_phr);
        end
        cnt_hr   += int'(bus.hr_tick_o);
        cnt_min  += int'(bus.min_tick_o);
        obs_mode  = int'(bus.mode);
        @(posedge clk_1Hz);
        model_upd(bm, bi, r);
    endtask

    initial begin
        int bm, bi, m10, m11, m18, m19;
        bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
        bus.sec_tick = 1'b0; bus.min_carry = 1'b0;

        // reset with both buttons held across the release
        step(1, 1, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        cnt_hr = 0; cnt_min = 0;
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
        chk("rst_hold_mode", obs_mode, 0);
        chk("rst_hold_pulses", cnt_hr + cnt_min, 0);
        step(0, 0, 0, 0, 0);

        // RUN pass-through
        cnt_hr = 0; cnt_min = 0;
        for (int c = 0; c < 11; c++) step(0, 0, (c == 5) ? 1 : 0, (c == 9) ? 1 : 0, 0);
        chk("run_min_cnt", cnt_min, 1);
        chk("run_hr_cnt", cnt_hr, 1);

        // SET_HR with three increment presses
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("enter_sethr", obs_mode, 1);
        cnt_hr = 0; cnt_min = 0;
        for (int p = 0; p < 3; p++) begin
            step(0, 1, 0, 0, 0);
            step(0, 0, 0, 0, 0);
        end
        chk("sethr_hr_cnt", cnt_hr, 3);
        chk("sethr_min_cnt", cnt_min, 0);

        // SET_MIN: carry suppressed, then mode+inc together
        step(1, 0, 0, 0, 0);
        cnt_hr = 0; cnt_min = 0;
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("carry_sup_hr", cnt_hr, 0);
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("prio_mode", obs_mode, 0);
        chk("prio_pulses", cnt_hr + cnt_min, 0);

        // timeout from SET_HR, idle
        m10 = -1; m11 = -1;
        step(1, 0, 0, 0, 0);
        for (int k = 1; k <= 11; k++) begin
            step(0, 0, 0, 0, 0);
            if (k == 10) m10 = obs_mode;
            if (k == 11) m11 = obs_mode;
        end
        chk("tmo_last_set", m10, 1);
        chk("tmo_run", m11, 0);

        // timeout restarted by an inc press at cycle 8
        m18 = -1; m19 = -1;
        step(1, 0, 0, 0, 0);
        for (int k = 1; k <= 19; k++) begin
            step(0, (k == 8) ? 1 : 0, 0, 0, 0);
            if (k == 18) m18 = obs_mode;
            if (k == 19) m19 = obs_mode;
        end
        chk("tmo_restart_set", m18, 1);
        chk("tmo_restart_run", m19, 0);

        // hold btn_inc six cycles in SET_MIN
        step(1, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
        chk("enter_setmin", obs_mode, 2);
        cnt_hr = 0; cnt_min = 0;
        for (int k = 0; k < 6; k++) step(0, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0);
`ifdef SET_AUTOREPEAT_EN
        chk("hold_min_cnt", cnt_min, 5);
`else
        chk("hold_min_cnt", cnt_min, 1);
`endif
        chk("hold_hr_cnt", cnt_hr, 0);

        // reset coinciding with a press cancels the pulse
        step(1, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
        cnt_hr = 0; cnt_min = 0;
        step(0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("rst_mid_mode", obs_mode, 0);
        chk("rst_mid_pulses", cnt_hr + cnt_min, 0);

        // random buttons, carries and occasional reset
        bm = 0; bi = 0;
        for (int n = 0; n < 3000; n++) begin
            bm = ($urandom_range(0, 5) == 0) ? 1 - bm : bm;
            bi = ($urandom_range(0, 3) == 0) ? 1 - bi : bi;
            step(bm, bi, ($urandom_range(0, 3) == 0) ? 1 : 0,
                 ($urandom_range(0, 3) == 0) ? 1 : 0,
                 ($urandom_range(0, 199) == 0) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-setting controller sitting between the seconds stage and the minutes/hours counters of the 24-hour clock. It drives the `tick` input of the minutes counter and the tick input of the hours counter. In RUN mode it passes the normal carry chain through. In SET modes it generates one-cycle adjustment pulses from the increment button and suppresses carries. It also holds the seconds stage cleared and provides a blink enable for the display.

## Interface
- `TIMEOUT`, default 10: consecutive idle cycles (seconds) in a SET mode before automatic return to RUN. Legal range 2–63.
- `REPEAT_DELAY`, default 2: cycles `btn_inc` must be held after its rising edge before auto-repeat starts. Only used when `SET_AUTOREPEAT_EN` is defined. Legal range 1–15.
- `clk_1Hz`  in  1: system clock, 1 Hz.
- `rst`  in  1: reset rst, synchronous, active-high; clock clk_1Hz.
- `sec_tick`  in  1: one-cycle carry pulse from the seconds stage (59→0).
- `min_carry`  in  1: one-cycle carry pulse from the minutes counter (59→0).
- `btn_mode`  in  1: mode button level, already synchronized and debounced.
- `btn_inc`  in  1: increment button level, already synchronized and debounced.
- `min_tick_o`  out  1: tick into the minutes counter.
- `hr_tick_o`  out  1: tick into the hours counter.
- `sec_clr`  out  1: holds the seconds stage at 0.
- `mode`  out  2: 2'b00 RUN, 2'b01 SET_HR, 2'b10 SET_MIN. 2'b11 is unused.
- `blink`  out  1: display blank strobe for the field being set.

## Operation
- **Edge detection.** Registered `mode_q` / `inc_q` hold the previous-cycle button samples.
  - mode_evt = `btn_mode & ~mode_q`
  - inc_evt = `btn_inc & ~inc_q`
- **FSM.** States RUN, SET_HR, SET_MIN. On mode_evt: RUN→SET_HR→SET_MIN→RUN.
- **Timeout.** In SET states, a timeout counter (6 bits) behaves as follows:
  - Cleared on any mode_evt or inc_evt, and while `btn_inc` is held.
  - Otherwise increments by 1 each cycle.
  - When the counter equals TIMEOUT-1 and increments, the state goes to RUN and the counter clears.
  - The counter is held at 0 in RUN.
- **RUN outputs** (combinational pass-through, zero added latency):
  - `min_tick_o` = `sec_tick`
  - `hr_tick_o` = `min_carry`
  - `sec_clr` = 0, `blink` = 0
- **SET_HR outputs:**
  - A registered pulse `hr_tick_o` = 1 in the cycle after inc_evt.
  - `min_tick_o` = 0.
  - `sec_tick` and `min_carry` are ignored.
- **SET_MIN outputs:**
  - A registered pulse `min_tick_o` = 1 in the cycle after inc_evt.
  - `hr_tick_o` = 0. Minute wrap 59→0 must not advance hours, so `min_carry` is suppressed.
- **Common to both SET states:** `sec_clr` = 1 (level), and `blink` toggles every cycle.
- **Mode/inc priority.** If mode_evt and inc_evt occur in the same cycle, mode_evt wins and the inc press is discarded. No adjustment pulse is issued to either counter.
- **State-change suppression.** A set pulse scheduled in the last cycle of a state is still issued (registered). However, no pulse is ever issued in RUN except the pass-through.
- **Pulse width.** Set pulses are exactly one cycle wide. A held button yields one pulse, unless auto-repeat is compiled in.

## Timing
- **Reset values.** After a cycle with `rst` = 1:
  - state RUN, `mode` = 00
  - `mode_q` = 1, `inc_q` = 1, so a button held through reset does not create an event
  - timeout = 0, repeat count = 0, `blink` = 0, pending set pulses = 0
  - `min_tick_o` and `hr_tick_o` then follow the RUN pass-through; they are 0 when the inputs are 0.
- **Latencies.**
  - Mode change: `mode` updates in the cycle after the `btn_mode` rising sample.
  - Set pulse: 1 cycle after the `btn_inc` rising sample.
  - RUN pass-through: 0 cycles.
- **Reset mid-SET.** Returns to RUN in the next cycle. Any pending set pulse is cancelled.
- **Timeout boundary.** TIMEOUT idle cycles after the last event, `mode` reads 00.

## Configuration
- **`SET_AUTOREPEAT_EN` defined:**
  - A 4-bit hold counter starts at inc_evt and counts cycles while `btn_inc` stays 1.
  - Once the counter reaches REPEAT_DELAY, one set pulse is issued every cycle while the button is held, in the active field.
  - Releasing the button clears the counter.
  - A mode_evt clears the counter and stops the repeat.
- **Not defined:** the hold counter is absent. Only inc_evt produces pulses; holding the button produces nothing further.

## Test plan
- **Reset with buttons held.** `rst` for 2 cycles with `btn_mode` = 1 and `btn_inc` = 1 held across the release → `mode` = 00, no pulses, `sec_clr` = 0.
- **RUN pass-through.** In RUN, drive `sec_tick` = 1 at cycle 5 and `min_carry` = 1 at cycle 9 → `min_tick_o` = 1 at cycle 5 only and `hr_tick_o` = 1 at cycle 9 only, with zero latency.
- **Set sequence.**
  - One mode press → `mode` = 01, `sec_clr` = 1, `blink` alternates.
  - Then 3 inc presses → exactly 3 single-cycle `hr_tick_o` pulses, each one cycle after its press; `min_tick_o` stays 0.
- **Carry suppression and priority.**
  - In SET_MIN, drive `min_carry` = 1 → `hr_tick_o` stays 0.
  - Press mode and inc in the same cycle → `mode` = 00 and no pulse on either output.
- **Timeout.** Enter SET_HR with TIMEOUT = 10 and stay idle → `mode` = 01 for cycles 1–9 after entry and `mode` = 00 at cycle 10. An inc press at cycle 8 restarts the count.
- **Auto-repeat** (`SET_AUTOREPEAT_EN` defined, REPEAT_DELAY = 2). Hold `btn_inc` for 6 cycles in SET_MIN → 1 pulse for the edge, then 1 pulse per cycle once the hold reaches 2 cycles. Without the macro, the same stimulus → exactly 1 pulse.
